// File: rtl/seq_pkg.sv
// Shared state encodings and opcode constants for the instruction sequencer
// and its control decoder.
package seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_FETCH = 3'd1;
    localparam state_t S_EXEC  = 3'd2;
    localparam state_t S_MEM   = 3'd3;
    localparam state_t S_HALT  = 3'd4;
    localparam state_t S_ERROR = 3'd5;

    localparam logic [3:0] OP_JMP  = 4'b0000;
    localparam logic [3:0] OP_JC1  = 4'b0001;
    localparam logic [3:0] OP_JC2  = 4'b0010;
    localparam logic [3:0] OP_JC3  = 4'b0011;
    localparam logic [3:0] OP_JC4  = 4'b0100;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_LD   = 4'b1000;
    localparam logic [3:0] OP_NOP  = 4'b1001;
    localparam logic [3:0] OP_HALT = 4'b1011;
    localparam logic [3:0] OP_CMP  = 4'b1100;

    function automatic logic is_cond_jump(input logic [3:0] op);
        return (op >= OP_JC1) && (op <= OP_JC4);
    endfunction

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_STR);
    endfunction

endpackage

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/EXEC control strobes, data memory
// handshake with a wait-cycle timeout, and a saturating retire counter.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNTW    = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [3:0]      opcode,
    input  logic [3:0]      flags,
    input  logic            mem_ack,
    output logic            ir_load,
    output logic            pc_en,
    output logic            pc_load,
    output logic            reg_wr_en,
    output logic            mem_req,
    output logic            mem_we,
    output logic            done,
    output logic            err,
    output logic [CNTW-1:0] retired
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT - 1);

    state_t          state;
    state_t          next_state;
    logic [TW-1:0]   wait_cnt;
    logic            mem_st;

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_FETCH;
            S_FETCH: next_state = S_EXEC;
            S_EXEC: begin
                if (opcode == OP_HALT)
                    next_state = S_HALT;
                else if (is_mem_op(opcode))
                    next_state = S_MEM;
                else
                    next_state = S_FETCH;
            end
            // An ack arriving on the final allowed wait cycle still completes.
            S_MEM: begin
                if (mem_ack)
                    next_state = S_FETCH;
                else if (wait_cnt == LIMIT)
                    next_state = S_ERROR;
            end
            S_HALT:  next_state = S_HALT;
            S_ERROR: next_state = S_ERROR;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        ir_load   = 1'b0;
        pc_en     = 1'b0;
        pc_load   = 1'b0;
        reg_wr_en = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            S_FETCH: ir_load = 1'b1;
            S_EXEC: begin
                if (opcode != OP_HALT && !is_mem_op(opcode)) begin
                    pc_en = 1'b1;
                    if (opcode == OP_JMP)
                        pc_load = 1'b1;
                    else if (is_cond_jump(opcode))
                        pc_load = flags[opcode[1:0] - 2'd1];
                    else if (opcode != OP_CMP && opcode != OP_NOP)
                        reg_wr_en = 1'b1;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = mem_st;
                if (mem_ack) begin
                    pc_en     = 1'b1;
                    reg_wr_en = !mem_st;
                end
            end
            S_HALT:  done = 1'b1;
            S_ERROR: err  = 1'b1;
            default: ;
        endcase
    end

    // The store/load kind is captured on leaving EXEC so mem_we holds steady
    // for the whole access even if the opcode field moves.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            mem_st   <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state <= next_state;
            if (state == S_EXEC)
                mem_st <= (opcode == OP_STR);
            if (state == S_MEM)
                wait_cnt <= wait_cnt + TW'(1);
            else
                wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            retired <= '0;
        else if (pc_en && retired != {CNTW{1'b1}})
            retired <= retired + CNTW'(1);
    end

endmodule
